// File: rtl/uart_time_cmd_parser.sv
`default_nettype none
// ============================================================================
// Module      : uart_time_cmd_parser
// Description : Parses a "set time" command from a UART byte stream.
//               Command format: 'T' or 't', six ASCII digits HHMMSS, CR.
//               A valid, in-range command updates the hour/minute/second
//               outputs and pulses o_set_valid. A malformed or out-of-range
//               command pulses o_err. Bytes received while idle (other than
//               'T'/'t') are ignored silently so that single-character
//               commands can share the same UART stream.
//
//               Optional feature (compile-time macro CMD_TIMEOUT_EN):
//               aborts a partial command with o_err when more than
//               TIMEOUT_CYC-1 idle clock cycles pass between bytes.
//
// Parameters  : TIMEOUT_CYC  max idle clk cycles between command bytes
// Ports       : clk          system clock, rising edge
//               reset        asynchronous active-high reset
//               i_rx_data    received byte, valid when i_rx_done = 1
//               i_rx_done    one-cycle strobe, new byte available
//               o_set_valid  one-cycle strobe, new time value on o_set_*
//               o_set_hour   parsed hour   (0-23)
//               o_set_min    parsed minute (0-59)
//               o_set_sec    parsed second (0-59)
//               o_err        one-cycle strobe, command aborted
//               o_busy       high while a command is in progress
//
// Revision    : 1.0  initial release
// ============================================================================
module uart_time_cmd_parser #(
    parameter int TIMEOUT_CYC = 100_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] i_rx_data,
    input  logic       i_rx_done,
    output logic       o_set_valid,
    output logic [4:0] o_set_hour,
    output logic [5:0] o_set_min,
    output logic [5:0] o_set_sec,
    output logic       o_err,
    output logic       o_busy
);

    localparam logic [7:0] c_CHAR_T_UC = 8'h54;
    localparam logic [7:0] c_CHAR_T_LC = 8'h74;
    localparam logic [7:0] c_CHAR_CR   = 8'h0D;
    localparam logic [7:0] c_CHAR_0    = 8'h30;
    localparam logic [7:0] c_CHAR_9    = 8'h39;
    localparam logic [2:0] c_LAST_IDX  = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_DIGIT   = 2'd1,
        ST_WAIT_CR = 2'd2
    } state_t;

    state_t      r_state;
    logic [2:0]  r_idx;
    // Six BCD digits, first received digit ends up in the top nibble.
    logic [23:0] r_digits;

    logic       w_is_cmd;
    logic       w_is_digit;
    logic       w_is_cr;
    logic       w_tmo_hit;
    logic [6:0] w_hour;
    logic [6:0] w_min;
    logic [6:0] w_sec;
    logic       w_in_range;

    assign w_is_cmd   = (i_rx_data == c_CHAR_T_UC) || (i_rx_data == c_CHAR_T_LC);
    assign w_is_digit = (i_rx_data >= c_CHAR_0) && (i_rx_data <= c_CHAR_9);
    assign w_is_cr    = (i_rx_data == c_CHAR_CR);

    assign w_hour = ({3'b000, r_digits[23:20]} * 7'd10) + {3'b000, r_digits[19:16]};
    assign w_min  = ({3'b000, r_digits[15:12]} * 7'd10) + {3'b000, r_digits[11:8]};
    assign w_sec  = ({3'b000, r_digits[7:4]}   * 7'd10) + {3'b000, r_digits[3:0]};

    assign w_in_range = (w_hour <= 7'd23) && (w_min <= 7'd59) && (w_sec <= 7'd59);

    assign o_busy = (r_state != ST_IDLE);

`ifdef CMD_TIMEOUT_EN
    localparam int c_CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [c_CNT_W-1:0] c_TMO_LAST = c_CNT_W'(TIMEOUT_CYC - 1);

    logic [c_CNT_W-1:0] r_tmo_cnt;

    // A byte arriving on the expiry cycle takes priority over the timeout.
    assign w_tmo_hit = (r_state != ST_IDLE) && !i_rx_done && (r_tmo_cnt == c_TMO_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tmo_cnt <= '0;
        end else if (i_rx_done || (r_state == ST_IDLE) || w_tmo_hit) begin
            r_tmo_cnt <= '0;
        end else begin
            r_tmo_cnt <= r_tmo_cnt + c_CNT_W'(1);
        end
    end
`else
    assign w_tmo_hit = 1'b0;
`endif

    if (TIMEOUT_CYC < 2) begin : g_cfg_check
        $error("uart_time_cmd_parser: TIMEOUT_CYC must be at least 2");
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_idx       <= 3'd0;
            r_digits    <= 24'd0;
            o_set_valid <= 1'b0;
            o_err       <= 1'b0;
            o_set_hour  <= 5'd0;
            o_set_min   <= 6'd0;
            o_set_sec   <= 6'd0;
        end else begin
            o_set_valid <= 1'b0;
            o_err       <= 1'b0;

            if (w_tmo_hit) begin
                o_err   <= 1'b1;
                r_state <= ST_IDLE;
                r_idx   <= 3'd0;
            end else if (i_rx_done) begin
                if (w_is_cmd) begin
                    // 'T'/'t' (re)starts a command from any state, never an error.
                    r_state  <= ST_DIGIT;
                    r_idx    <= 3'd0;
                    r_digits <= 24'd0;
                end else begin
                    case (r_state)
                        ST_IDLE: begin
                            r_state <= ST_IDLE;
                        end
                        ST_DIGIT: begin
                            if (w_is_digit) begin
                                // Low nibble of '0'..'9' equals the digit value.
                                r_digits <= {r_digits[19:0], i_rx_data[3:0]};
                                if (r_idx == c_LAST_IDX) begin
                                    r_state <= ST_WAIT_CR;
                                    r_idx   <= 3'd0;
                                end else begin
                                    r_idx <= r_idx + 3'd1;
                                end
                            end else begin
                                o_err   <= 1'b1;
                                r_state <= ST_IDLE;
                                r_idx   <= 3'd0;
                            end
                        end
                        ST_WAIT_CR: begin
                            r_state <= ST_IDLE;
                            r_idx   <= 3'd0;
                            if (w_is_cr && w_in_range) begin
                                o_set_valid <= 1'b1;
                                o_set_hour  <= w_hour[4:0];
                                o_set_min   <= w_min[5:0];
                                o_set_sec   <= w_sec[5:0];
                            end else begin
                                o_err <= 1'b1;
                            end
                        end
                        default: begin
                            r_state <= ST_IDLE;
                            r_idx   <= 3'd0;
                        end
                    endcase
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_time_cmd_parser.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_time_cmd_parser
// Description : Scoreboard bench for uart_time_cmd_parser. Directed command
//               sequences followed by randomized commands; a command-level
//               reference model predicts strobes, busy and held time values.
// Revision    : 1.0  initial release
// ============================================================================
module tb_uart_time_cmd_parser;

    localparam int TMO = 50;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] rx_data = 8'h00;
    logic       rx_done = 1'b0;
    logic       set_valid;
    logic [4:0] set_hour;
    logic [5:0] set_min;
    logic [5:0] set_sec;
    logic       err;
    logic       busy;

    uart_time_cmd_parser #(.TIMEOUT_CYC(TMO)) dut (
        .clk        (clk),
        .reset      (reset),
        .i_rx_data  (rx_data),
        .i_rx_done  (rx_done),
        .o_set_valid(set_valid),
        .o_set_hour (set_hour),
        .o_set_min  (set_min),
        .o_set_sec  (set_sec),
        .o_err      (err),
        .o_busy     (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cyc;
        bit is_err;
        int h;
        int m;
        int s;
    } ev_t;

    ev_t exp_q[$];
    int  cyc = 0;
    int  n_tests = 0;
    int  n_fail = 0;

    // Reference model state: command in progress, digits collected so far,
    // idle cycles since the last byte, and last accepted time.
    bit  m_in_cmd = 1'b0;
    int  m_digs[$];
    int  m_idle = 0;
    int  m_h = 0;
    int  m_m = 0;
    int  m_s = 0;

    task automatic chk(input bit ok, input string name, input string got, input string want);
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %s, expected %s", name, cyc, got, want);
        end
    endtask

    function automatic void push_ev(input bit is_err, input int h, input int m, input int s);
        ev_t e;
        e.cyc = cyc + 1;
        e.is_err = is_err;
        e.h = h;
        e.m = m;
        e.s = s;
        exp_q.push_back(e);
    endfunction

    // Called once per clock for the stimulus applied to the next edge.
    task automatic model(input bit done, input logic [7:0] b);
        int h, m, s;
        if (!done) begin
`ifdef CMD_TIMEOUT_EN
            if (m_in_cmd) begin
                m_idle++;
                if (m_idle >= TMO) begin
                    push_ev(1'b1, 0, 0, 0);
                    m_in_cmd = 1'b0;
                end
            end
`endif
        end else begin
            m_idle = 0;
            if (b == 8'h54 || b == 8'h74) begin
                m_in_cmd = 1'b1;
                m_digs.delete();
            end else if (!m_in_cmd) begin
                m_in_cmd = 1'b0;
            end else if (m_digs.size() < 6) begin
                if (b >= 8'h30 && b <= 8'h39) begin
                    m_digs.push_back(int'(b) - 48);
                end else begin
                    push_ev(1'b1, 0, 0, 0);
                    m_in_cmd = 1'b0;
                end
            end else begin
                m_in_cmd = 1'b0;
                if (b == 8'h0D) begin
                    h = m_digs[0] * 10 + m_digs[1];
                    m = m_digs[2] * 10 + m_digs[3];
                    s = m_digs[4] * 10 + m_digs[5];
                    if (h <= 23 && m <= 59 && s <= 59) begin
                        push_ev(1'b0, h, m, s);
                        m_h = h;
                        m_m = m;
                        m_s = s;
                    end else begin
                        push_ev(1'b1, 0, 0, 0);
                    end
                end else begin
                    push_ev(1'b1, 0, 0, 0);
                end
            end
        end
    endtask

    task automatic step(input bit done, input logic [7:0] d);
        @(negedge clk);
        rx_done = done;
        rx_data = done ? d : 8'($urandom);
        model(done, d);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00);
    endtask

    task automatic send(input string str, input bit with_cr);
        for (int i = 0; i < str.len(); i++) step(1'b1, str[i]);
        if (with_cr) step(1'b1, 8'h0D);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        rx_done = 1'b0;
        m_in_cmd = 1'b0;
        m_idle = 0;
        m_digs.delete();
        m_h = 0;
        m_m = 0;
        m_s = 0;
        exp_q.delete();
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic chk_time(input int h, input int m, input int s, input string name);
        chk(set_hour == h && set_min == m && set_sec == s, name,
            $sformatf("%0d:%0d:%0d", set_hour, set_min, set_sec),
            $sformatf("%0d:%0d:%0d", h, m, s));
    endtask

    // Monitor: samples 1 time unit after each rising edge.
    initial begin
        ev_t e;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                e = exp_q.pop_front();
                chk(1'b0, "missing_strobe", "no strobe",
                    $sformatf("%s at cycle %0d", e.is_err ? "err" : "set_valid", e.cyc));
            end
            if (set_valid || err) begin
                chk(!(set_valid && err), "strobe_exclusive",
                    $sformatf("valid=%0b err=%0b", set_valid, err), "only one strobe");
                if (exp_q.size() == 0) begin
                    chk(1'b0, "unexpected_strobe",
                        $sformatf("valid=%0b err=%0b", set_valid, err), "no strobe");
                end else begin
                    e = exp_q.pop_front();
                    chk(e.cyc == cyc, "strobe_cycle", $sformatf("%0d", cyc), $sformatf("%0d", e.cyc));
                    chk(err == e.is_err, "strobe_kind",
                        $sformatf("valid=%0b err=%0b", set_valid, err),
                        e.is_err ? "err" : "set_valid");
                    if (!e.is_err) begin
                        chk(set_hour == e.h && set_min == e.m && set_sec == e.s, "set_time",
                            $sformatf("%0d:%0d:%0d", set_hour, set_min, set_sec),
                            $sformatf("%0d:%0d:%0d", e.h, e.m, e.s));
                    end
                end
            end
            chk(busy == m_in_cmd, "busy", $sformatf("%0b", busy), $sformatf("%0b", m_in_cmd));
            chk(set_hour == m_h && set_min == m_m && set_sec == m_s, "held_time",
                $sformatf("%0d:%0d:%0d", set_hour, set_min, set_sec),
                $sformatf("%0d:%0d:%0d", m_h, m_m, m_s));
        end
    end

    initial begin
        logic [7:0] q[$];
        int kind, h, m, s, gap, cut;

        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk(busy == 1'b0 && set_valid == 1'b0 && err == 1'b0, "reset_state",
            $sformatf("busy=%0b valid=%0b err=%0b", busy, set_valid, err), "all 0");
        reset = 1'b0;

        send("T123456", 1'b1);
        idle(3);
        chk_time(12, 34, 56, "basic_set");

        send("t235959", 1'b1);
        idle(2);
        send("T240000", 1'b1);
        idle(3);
        chk_time(23, 59, 59, "range_err_hold");

        send("T12a", 1'b0);
        idle(2);
        chk(busy == 1'b0, "bad_char_busy", $sformatf("%0b", busy), "0");
        send("T000000", 1'b1);
        idle(3);
        chk_time(0, 0, 0, "zero_set");

        send("T1234T010203", 1'b1);
        send("pu", 1'b0);
        idle(3);
        chk_time(1, 2, 3, "restart_set");

`ifdef CMD_TIMEOUT_EN
        send("T12", 1'b0);
        idle(TMO + 2);
        chk(busy == 1'b0, "timeout_busy", $sformatf("%0b", busy), "0");
        send("T12", 1'b0);
        idle(TMO - 1);
        step(1'b1, 8'h33);
        idle(2);
        chk(busy == 1'b1, "expiry_byte_busy", $sformatf("%0b", busy), "1");
        send("456", 1'b1);
        idle(3);
        chk_time(12, 34, 56, "expiry_byte_set");
`endif

        send("T1234", 1'b0);
        do_reset();
        chk(busy == 1'b0 && set_hour == 0 && set_min == 0 && set_sec == 0, "mid_cmd_reset",
            $sformatf("busy=%0b %0d:%0d:%0d", busy, set_hour, set_min, set_sec), "busy=0 0:0:0");
        step(1'b1, 8'h0D);
        idle(3);

        for (int n = 0; n < 300; n++) begin
            kind = $urandom_range(0, 9);
            q.delete();
            if (kind == 8) begin
                cut = $urandom_range(1, 4);
                for (int i = 0; i < cut; i++) q.push_back(8'($urandom));
            end else begin
                q.push_back($urandom_range(0, 1) ? 8'h54 : 8'h74);
                if (kind <= 3) begin
                    h = $urandom_range(0, 23);
                    m = $urandom_range(0, 59);
                    s = $urandom_range(0, 59);
                    q.push_back(8'(48 + h / 10));
                    q.push_back(8'(48 + h % 10));
                    q.push_back(8'(48 + m / 10));
                    q.push_back(8'(48 + m % 10));
                    q.push_back(8'(48 + s / 10));
                    q.push_back(8'(48 + s % 10));
                end else begin
                    for (int i = 0; i < 6; i++) q.push_back(8'(48 + $urandom_range(0, 9)));
                end
                q.push_back(8'h0D);
                if (kind == 5) q[$urandom_range(1, 6)] = 8'(8'h61 + $urandom_range(0, 25));
                if (kind == 6) q[7] = 8'($urandom);
                if (kind == 7) begin
                    cut = $urandom_range(1, 7);
                    while (q.size() > cut) q.pop_back();
                    q.push_back(8'h54);
                    for (int i = 0; i < 6; i++) q.push_back(8'(48 + $urandom_range(0, 5)));
                    q.push_back(8'h0D);
                end
            end
            cut = (kind == 9 && $urandom_range(0, 2) == 0) ? $urandom_range(1, 7) : 99;
            for (int i = 0; i < q.size(); i++) begin
                if (i == cut) begin
                    do_reset();
                    break;
                end
                step(1'b1, q[i]);
                gap = ($urandom_range(0, 29) == 0) ? $urandom_range(TMO - 3, TMO + 3)
                                                   : $urandom_range(0, 3);
                idle(gap);
            end
        end

        idle(TMO + 5);
        chk(exp_q.size() == 0, "scoreboard_empty", $sformatf("%0d pending", exp_q.size()), "0 pending");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_time_cmd_parser.md
UART_TIME_CMD_PARSER -- requirements
Module: uart_time_cmd_parser

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 100_000_000, meaning max idle clk cycles allowed between consecutive command bytes.
REQ-002 SHALL have port clk  input  1  system clock; all state on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port i_rx_data  input  8  received UART byte, valid only when i_rx_done=1.
REQ-005 SHALL have port i_rx_done  input  1  one-cycle strobe, new byte on i_rx_data.
REQ-006 SHALL have port o_set_valid  output  1  one-cycle strobe, new time-set value valid.
REQ-007 SHALL have port o_set_hour  output  5  parsed hour, 0-23.
REQ-008 SHALL have port o_set_min  output  6  parsed minute, 0-59.
REQ-009 SHALL have port o_set_sec  output  6  parsed second, 0-59.
REQ-010 SHALL have port o_err  output  1  one-cycle strobe, command aborted (bad char, range, or timeout).
REQ-011 SHALL have port o_busy  output  1  high while a command is in progress (state != IDLE).

Function
REQ-012 SHALL accept the command 'T' or 't' (8'h54/8'h74), then exactly six ASCII digits HHMMSS, then CR (8'h0D).
REQ-013 SHALL implement states IDLE, DIGIT, WAIT_CR; a 3-bit digit index 0-5 is used within DIGIT.
REQ-014 SHALL, in IDLE, ignore every byte except 'T'/'t' without asserting o_err, so single-char button commands pass through untouched.
REQ-015 SHALL go IDLE->DIGIT with index 0 on 'T'/'t'.
REQ-016 SHALL, in DIGIT, store each byte in 8'h30-8'h39 as a 4-bit value (byte-8'h30) and increment the index; SHALL go to WAIT_CR after index 5.
REQ-017 SHALL restart at DIGIT index 0 on receipt of 'T'/'t' while in DIGIT or WAIT_CR, with no o_err.
REQ-018 SHALL, on any other non-digit byte in DIGIT, or any byte other than CR/'T'/'t' in WAIT_CR, pulse o_err for one cycle and return to IDLE.
REQ-019 SHALL, on CR in WAIT_CR, compute hour=H1*10+H0, min=M1*10+M0, sec=S1*10+S0 at 7-bit width, then truncate to the output widths.
REQ-020 SHALL, if hour<=23, min<=59 and sec<=59, update o_set_hour/min/sec and pulse o_set_valid exactly one cycle after the CR i_rx_done cycle.
REQ-021 SHALL, if any field is out of range, leave the outputs unchanged and pulse o_err one cycle after the CR i_rx_done cycle.
REQ-022 SHALL return to IDLE after handling CR in both cases.
REQ-023 SHALL hold o_set_hour/min/sec stable between valid commands.
REQ-024 SHALL never assert o_set_valid and o_err in the same cycle.

Reset
REQ-025 SHALL, on reset assertion, immediately clear the state to IDLE, the index and digit registers to 0, and all outputs to 0.
REQ-026 SHALL, on reset mid-command, discard the partial command and emit no o_set_valid or o_err after release.

Configuration
REQ-027 SHALL compile the inter-byte timeout only when CMD_TIMEOUT_EN is defined.
REQ-028 SHALL, with CMD_TIMEOUT_EN defined, clear a counter on every i_rx_done and on entering IDLE, and count while not in IDLE.
REQ-029 SHALL, with CMD_TIMEOUT_EN defined, pulse o_err and return to IDLE when the counter reaches TIMEOUT_CYC-1.
REQ-030 SHALL, with CMD_TIMEOUT_EN defined, let i_rx_done win when it coincides with timeout expiry: the byte is processed and no timeout error occurs.
REQ-031 SHALL, without CMD_TIMEOUT_EN, contain no counter; a partial command then waits indefinitely.

Verification
REQ-032 SHALL cover: "T123456\r" -> o_set_valid 1 cycle after CR, hour=12, min=34, sec=56, o_err=0.
REQ-033 SHALL cover: "t235959\r" then "T240000\r" -> first sets 23:59:59; second pulses o_err once and outputs stay 23:59:59.
REQ-034 SHALL cover: "T12a" -> o_err pulse after 'a', o_busy=0; then "T000000\r" -> hour=min=sec=0 with o_set_valid.
REQ-035 SHALL cover: "T1234T010203\r" -> no o_err; set 01:02:03; idle bytes 'p','u' -> no pulses.
REQ-036 SHALL cover, with CMD_TIMEOUT_EN and TIMEOUT_CYC=50: "T12" then 50 idle cycles -> o_err at expiry, o_busy=0; byte arriving on the expiry cycle -> no o_err.
REQ-037 SHALL cover: reset pulsed after "T1234" -> all outputs 0, state IDLE; following "\r" -> no pulse.
